// File: rtl/uart_regs_fifo_pkg.sv
// Register map, field layout and interrupt bit indices for the UART CSR block.
package uart_regs_fifo_pkg;

  // Register byte offsets from BASE_ADDR
  localparam int unsigned DATA_ADDR    = 32'h04;
  localparam int unsigned STAT_ADDR    = 32'h0C;
  localparam int unsigned CTRL_ADDR    = 32'h10;
  localparam int unsigned LPMODE_ADDR  = 32'h14;
  localparam int unsigned LEVEL_ADDR   = 32'h18;
  localparam int unsigned INTSTAT_ADDR = 32'h20;
  localparam int unsigned INTEN_ADDR   = 32'h24;
  localparam int unsigned ID_ADDR      = 32'h140;

  // Register reset values
  localparam logic [31:0] DATA_RESET    = 32'h0;
  localparam logic [31:0] STAT_RESET    = 32'h210;
  localparam logic [31:0] CTRL_RESET    = 32'h0;
  localparam logic [31:0] LPMODE_RESET  = 32'h0;
  localparam logic [31:0] LEVEL_RESET   = 32'h0;
  localparam logic [31:0] INTSTAT_RESET = 32'h0;
  localparam logic [31:0] INTEN_RESET   = 32'h0;
  localparam logic [31:0] ID_RESET      = 32'hcafe0666;

  // DATA read fields
  localparam int DATA_FERR_LSB = 16;
  localparam int DATA_PERR_LSB = 17;

  // STAT fields (all 1 bit)
  localparam int STAT_BUSY_LSB = 2;
  localparam int STAT_RXE_LSB  = 4;
  localparam int STAT_TXF_LSB  = 8;
  localparam int STAT_TXE_LSB  = 9;
  localparam int STAT_RXF_LSB  = 10;
  localparam logic [31:0] STAT_TXE_MASK = 32'h1 << STAT_TXE_LSB;
  localparam logic [31:0] STAT_RXF_MASK = 32'h1 << STAT_RXF_LSB;
  localparam logic STAT_TXE_RESET = 1'b1;
  localparam logic STAT_RXF_RESET = 1'b0;

  // CTRL fields
  localparam int CTRL_BAUD_LSB = 0;
  localparam int CTRL_TXEN_LSB = 4;
  localparam int CTRL_RXEN_LSB = 5;
  localparam int CTRL_TXST_LSB = 6;

  // LPMODE fields
  localparam int LPMODE_DIV_LSB   = 0;
  localparam int LPMODE_DIV_WIDTH = 8;
  localparam int LPMODE_EN_LSB    = 31;
  localparam logic [31:0] LPMODE_DIV_MASK = 32'h0000_00FF;
  localparam logic [31:0] LPMODE_EN_MASK  = 32'h8000_0000;

  // LEVEL fields
  localparam int LEVEL_TX_LSB   = 0;
  localparam int LEVEL_RX_LSB   = 16;
  localparam int LEVEL_WIDTH    = 16;
  localparam logic [31:0] LEVEL_TX_MASK = 32'h0000_FFFF;
  localparam logic [31:0] LEVEL_RX_MASK = 32'hFFFF_0000;

  // INTSTAT / INTEN fields
  localparam int INT_WIDTH = 4;
  localparam int INTEN_WIDTH = 4;
  localparam logic [31:0] INTEN_MASK   = 32'h0000_000F;
  localparam logic [31:0] INTSTAT_MASK = 32'h0000_000F;
  localparam logic [31:0] TXOVF_MASK   = 32'h0000_0004;
  localparam logic [31:0] RXOVF_MASK   = 32'h0000_0008;
  localparam logic TXOVF_RESET = 1'b0;
  localparam logic RXOVF_RESET = 1'b0;

  typedef enum logic [1:0] {
    INT_TX    = 2'd0,
    INT_RX    = 2'd1,
    INT_TXOVF = 2'd2,
    INT_RXOVF = 2'd3
  } int_bits_e;

endpackage

// File: rtl/uart_regs_fifo_fifo.sv
// Synchronous FIFO with a registered head word; power-of-2 depth, free-running wrap pointers.
module regs_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = head_q;
  // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer/count and the word that will sit at the head after this cycle.
  always_comb begin
    rd_d   = rd_q + AW'(do_pop);
    cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head_d = head_q;
    if (cnt_d == '0)                  head_d = '0;
    else if (do_push && wr_q == rd_d) head_d = din_i;
    else                              head_d = mem_q[rd_d];
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointers, count and head register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_q + AW'(do_push);
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end
endmodule

// File: rtl/uart_regs_fifo.sv
// UART CSR block: LocalBus register map, TX/RX FIFOs, W1C interrupts and registered irq.
module uart_regs_fifo
  import uart_regs_fifo_pkg::*;
#(
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 32,
  parameter int          CHAR_W     = 8,
  parameter int          TX_DEPTH   = 16,
  parameter int          RX_DEPTH   = 16,
  parameter int          BAUD_W     = 2,
  parameter logic [31:0] ID_VALUE   = 32'hcafe0666
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lb_waddr,
  input  logic [31:0]           lb_wdata,
  input  logic                  lb_wen,
  input  logic [3:0]            lb_wstrb,
  output logic                  lb_wready,
  input  logic [ADDR_WIDTH-1:0] lb_raddr,
  input  logic                  lb_ren,
  output logic [31:0]           lb_rdata,
  output logic                  lb_rvalid,
  output logic [CHAR_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [CHAR_W-1:0]     rx_data,
  input  logic                  rx_ferr,
  input  logic                  rx_perr,
  input  logic                  rx_valid,
  input  logic                  busy,
  output logic [BAUD_W-1:0]     ctrl_baud,
  output logic                  ctrl_txen,
  output logic                  ctrl_rxen,
  output logic                  ctrl_txst,
  output logic [7:0]            lpmode_div,
  output logic                  lpmode_en,
  output logic                  irq
);
  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] woff, roff;
  logic w_data, w_ctrl, w_lp, w_ist, w_ien, r_data;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_pop, rx_full, rx_empty;
  logic [TXCW-1:0] tx_cnt;
  logic [RXCW-1:0] rx_cnt;
  logic [CHAR_W+1:0] rx_head;

  logic [BAUD_W-1:0] baud_q;
  logic txen_q, rxen_q, txst_q, lpen_q, irq_q, rvalid_q;
  logic [7:0] lpdiv_q;
  logic [3:0] ist_q, ist_d, ist_set, ist_w1c, ien_q;
  logic [31:0] rdata_q, rdata_d;
  logic unused_bits;

  assign woff   = lb_waddr - ADDR_WIDTH'(BASE_ADDR);
  assign roff   = lb_raddr - ADDR_WIDTH'(BASE_ADDR);
  assign w_data = lb_wen && woff == ADDR_WIDTH'(DATA_ADDR);
  assign w_ctrl = lb_wen && woff == ADDR_WIDTH'(CTRL_ADDR);
  assign w_lp   = lb_wen && woff == ADDR_WIDTH'(LPMODE_ADDR);
  assign w_ist  = lb_wen && woff == ADDR_WIDTH'(INTSTAT_ADDR);
  assign w_ien  = lb_wen && woff == ADDR_WIDTH'(INTEN_ADDR);
  assign r_data = lb_ren && roff == ADDR_WIDTH'(DATA_ADDR);

  assign tx_push = w_data && lb_wstrb[0];
  assign tx_pop  = !tx_empty && tx_ready;
  assign rx_pop  = r_data && !rx_empty;

  regs_sync_fifo #(.WIDTH(CHAR_W), .DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push_i(tx_push), .din_i(lb_wdata[CHAR_W-1:0]), .pop_i(tx_pop),
    .head_o(tx_data), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt));

  regs_sync_fifo #(.WIDTH(CHAR_W+2), .DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push_i(rx_valid), .din_i({rx_perr, rx_ferr, rx_data}), .pop_i(rx_pop),
    .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt));

  assign tx_valid   = !tx_empty;
  assign lb_wready  = 1'b1;
  assign lb_rdata   = rdata_q;
  assign lb_rvalid  = rvalid_q;
  assign ctrl_baud  = baud_q;
  assign ctrl_txen  = txen_q;
  assign ctrl_rxen  = rxen_q;
  assign ctrl_txst  = txst_q;
  assign lpmode_div = lpdiv_q;
  assign lpmode_en  = lpen_q;
  assign irq        = irq_q;
  assign unused_bits = ^{lb_wstrb[2:1], lb_wdata[30:8]};

  // Interrupt status: hardware events OR'd in after the W1C so a same-cycle set wins.
  always_comb begin
    ist_set = '0;
    ist_set[INT_TX]    = tx_pop && tx_cnt == TXCW'(1) && !tx_push;
    ist_set[INT_RX]    = rx_valid && rx_empty;
    ist_set[INT_TXOVF] = tx_push && tx_full && !tx_pop;
    ist_set[INT_RXOVF] = rx_valid && rx_full && !rx_pop;
    ist_w1c = (w_ist && lb_wstrb[0]) ? lb_wdata[3:0] : 4'h0;
    ist_d   = (ist_q & ~ist_w1c) | ist_set;
  end

  // Read mux, sampled into the read data register.
  always_comb begin
    rdata_d = '0;
    case (roff)
      ADDR_WIDTH'(DATA_ADDR): if (!rx_empty) begin
        rdata_d[CHAR_W-1:0]   = rx_head[CHAR_W-1:0];
        rdata_d[DATA_FERR_LSB] = rx_head[CHAR_W];
        rdata_d[DATA_PERR_LSB] = rx_head[CHAR_W+1];
      end
      ADDR_WIDTH'(STAT_ADDR): begin
        rdata_d[STAT_BUSY_LSB] = busy;
        rdata_d[STAT_RXE_LSB]  = rx_empty;
        rdata_d[STAT_TXF_LSB]  = tx_full;
        rdata_d[STAT_TXE_LSB]  = tx_empty;
        rdata_d[STAT_RXF_LSB]  = rx_full;
      end
      ADDR_WIDTH'(CTRL_ADDR): begin
        rdata_d[CTRL_BAUD_LSB +: BAUD_W] = baud_q;
        rdata_d[CTRL_TXEN_LSB] = txen_q;
        rdata_d[CTRL_RXEN_LSB] = rxen_q;
      end
      ADDR_WIDTH'(LPMODE_ADDR): begin
        rdata_d[LPMODE_DIV_LSB +: LPMODE_DIV_WIDTH] = lpdiv_q;
        rdata_d[LPMODE_EN_LSB] = lpen_q;
      end
      ADDR_WIDTH'(LEVEL_ADDR): begin
        rdata_d[LEVEL_TX_LSB +: LEVEL_WIDTH] = LEVEL_WIDTH'(tx_cnt);
        rdata_d[LEVEL_RX_LSB +: LEVEL_WIDTH] = LEVEL_WIDTH'(rx_cnt);
      end
      ADDR_WIDTH'(INTSTAT_ADDR): rdata_d[INT_WIDTH-1:0] = ist_q;
      ADDR_WIDTH'(INTEN_ADDR):   rdata_d[INTEN_WIDTH-1:0] = ien_q;
      ADDR_WIDTH'(ID_ADDR):      rdata_d = ID_VALUE;
      default: rdata_d = '0;
    endcase
  end

  // Control/status registers, read port and irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q   <= '0;
      txen_q   <= 1'b0;
      rxen_q   <= 1'b0;
      txst_q   <= 1'b0;
      lpdiv_q  <= '0;
      lpen_q   <= 1'b0;
      ist_q    <= '0;
      ien_q    <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (w_ctrl && lb_wstrb[0]) begin
        baud_q <= lb_wdata[CTRL_BAUD_LSB +: BAUD_W];
        txen_q <= lb_wdata[CTRL_TXEN_LSB];
        rxen_q <= lb_wdata[CTRL_RXEN_LSB];
      end
      txst_q <= w_ctrl && lb_wstrb[0] && lb_wdata[CTRL_TXST_LSB];
      if (w_lp && lb_wstrb[0]) lpdiv_q <= lb_wdata[LPMODE_DIV_LSB +: LPMODE_DIV_WIDTH];
      if (w_lp && lb_wstrb[3]) lpen_q  <= lb_wdata[LPMODE_EN_LSB];
      if (w_ien && lb_wstrb[0]) ien_q  <= lb_wdata[INTEN_WIDTH-1:0];
      ist_q    <= ist_d;
      irq_q    <= |(ist_q & ien_q);
      rvalid_q <= lb_ren;
      if (lb_ren) rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_uart_regs_fifo.sv
// Bench for uart_regs_fifo: register table, directed corner sequences, random traffic vs queue model.
module tb_uart_regs_fifo;
  localparam logic [15:0] BASE = 16'h1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, lb_wen, lb_ren, lb_wready, lb_rvalid, tx_valid, tx_ready;
  logic rx_ferr, rx_perr, rx_valid, busy, ctrl_txen, ctrl_rxen, ctrl_txst, lpmode_en, irq;
  logic [15:0] lb_waddr, lb_raddr;
  logic [31:0] lb_wdata, lb_rdata;
  logic [3:0]  lb_wstrb;
  logic [7:0]  tx_data, rx_data, lpmode_div;
  logic [1:0]  ctrl_baud;

  uart_regs_fifo #(.BASE_ADDR(32'h1000)) dut (
    .clk(clk), .rst(rst), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wen(lb_wen),
    .lb_wstrb(lb_wstrb), .lb_wready(lb_wready), .lb_raddr(lb_raddr), .lb_ren(lb_ren),
    .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_ferr(rx_ferr), .rx_perr(rx_perr),
    .rx_valid(rx_valid), .busy(busy), .ctrl_baud(ctrl_baud), .ctrl_txen(ctrl_txen),
    .ctrl_rxen(ctrl_rxen), .ctrl_txst(ctrl_txst), .lpmode_div(lpmode_div),
    .lpmode_en(lpmode_en), .irq(irq));

  int checks = 0, errors = 0;

  // Reference model state
  logic [7:0] m_txq[$];
  logic [9:0] m_rxq[$];
  logic [3:0] m_ist, m_ien;
  logic [1:0] m_baud;
  logic [7:0] m_div;
  logic m_txen, m_rxen, m_lpen, m_txst, m_irq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus cycle of the model: returns the read value, advances state.
  task automatic model(output logic [31:0] erd);
    int tn0, rn0;
    logic txovf, rxovf;
    logic [3:0] w1c, setb;
    logic [15:0] wo, ro;
    wo = lb_waddr - BASE;
    ro = lb_raddr - BASE;
    tn0 = m_txq.size();
    rn0 = m_rxq.size();
    erd = 32'h0;
    case (ro)
      16'h004: if (rn0 > 0) erd = {14'd0, m_rxq[0][9], m_rxq[0][8], 8'd0, m_rxq[0][7:0]};
      16'h00C: erd = {21'd0, rn0 == 16, tn0 == 0, tn0 == 16, 3'd0, rn0 == 0, 1'b0, busy, 2'd0};
      16'h010: erd = {26'd0, m_rxen, m_txen, 2'd0, m_baud};
      16'h014: erd = {m_lpen, 23'd0, m_div};
      16'h018: erd = {16'(rn0), 16'(tn0)};
      16'h020: erd = {28'd0, m_ist};
      16'h024: erd = {28'd0, m_ien};
      16'h140: erd = 32'hcafe0666;
      default: erd = 32'h0;
    endcase
    if (rst) begin
      m_txq.delete(); m_rxq.delete();
      m_ist = 0; m_ien = 0; m_baud = 0; m_div = 0;
      m_txen = 0; m_rxen = 0; m_lpen = 0; m_txst = 0; m_irq = 0;
      return;
    end
    m_irq = |(m_ist & m_ien);
    txovf = 0;
    rxovf = 0;
    if (tn0 > 0 && tx_ready) void'(m_txq.pop_front());
    if (lb_wen && wo == 16'h004 && lb_wstrb[0]) begin
      if (m_txq.size() < 16) m_txq.push_back(lb_wdata[7:0]);
      else txovf = 1;
    end
    if (lb_ren && ro == 16'h004 && rn0 > 0) void'(m_rxq.pop_front());
    if (rx_valid) begin
      if (m_rxq.size() < 16) m_rxq.push_back({rx_perr, rx_ferr, rx_data});
      else rxovf = 1;
    end
    setb = {rxovf, txovf, rn0 == 0 && m_rxq.size() > 0, tn0 > 0 && m_txq.size() == 0};
    w1c = (lb_wen && wo == 16'h020 && lb_wstrb[0]) ? lb_wdata[3:0] : 4'h0;
    m_ist = (m_ist & ~w1c) | setb;
    m_txst = lb_wen && wo == 16'h010 && lb_wstrb[0] && lb_wdata[6];
    if (lb_wen && wo == 16'h010 && lb_wstrb[0]) begin
      m_baud = lb_wdata[1:0]; m_txen = lb_wdata[4]; m_rxen = lb_wdata[5];
    end
    if (lb_wen && wo == 16'h014 && lb_wstrb[0]) m_div = lb_wdata[7:0];
    if (lb_wen && wo == 16'h014 && lb_wstrb[3]) m_lpen = lb_wdata[31];
    if (lb_wen && wo == 16'h024 && lb_wstrb[0]) m_ien = lb_wdata[3:0];
  endtask

  // Apply the currently driven inputs for one clock, then compare outputs to the model.
  task automatic step(output logic [31:0] rd);
    logic [31:0] erd;
    logic erv;
    model(erd);
    erv = lb_ren && !rst;
    @(negedge clk);
    chk("rvalid", lb_rvalid, erv);
    if (erv) chk("rdata", lb_rdata, erd);
    chk("tx_valid", tx_valid, m_txq.size() > 0);
    if (m_txq.size() > 0) chk("tx_data", tx_data, m_txq[0]);
    chk("irq", irq, m_irq);
    chk("ctrl_txst", ctrl_txst, m_txst);
    chk("ctrl_outs", {ctrl_baud, ctrl_txen, ctrl_rxen, lpmode_div, lpmode_en},
        {m_baud, m_txen, m_rxen, m_div, m_lpen});
    chk("wready", lb_wready, 1'b1);
    rd = lb_rdata;
    lb_wen = 0; lb_ren = 0; rx_valid = 0; rst = 0;
  endtask

  task automatic idle();
    logic [31:0] d;
    step(d);
  endtask

  task automatic wr(input logic [15:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    lb_wen = 1; lb_waddr = BASE + off; lb_wdata = d; lb_wstrb = s;
    step(r);
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] off, input logic [31:0] exp);
    logic [31:0] r;
    lb_ren = 1; lb_raddr = BASE + off;
    step(r);
    chk(nm, r, exp);
  endtask

  task automatic rx_push(input logic [7:0] c, input logic fe, input logic pe);
    logic [31:0] r;
    rx_valid = 1; rx_data = c; rx_ferr = fe; rx_perr = pe;
    step(r);
  endtask

  typedef struct {
    string       nm;
    logic        wen;
    logic [15:0] wo;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        ren;
    logic [15:0] ro;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [31:0] r;
    tbl[0]  = '{"id",          0, 16'h000, 32'h0,          4'h0, 1, 16'h140, 32'hcafe0666};
    tbl[1]  = '{"ctrl_rst",    0, 16'h000, 32'h0,          4'h0, 1, 16'h010, 32'h0};
    tbl[2]  = '{"stat_rst",    0, 16'h000, 32'h0,          4'h0, 1, 16'h00C, 32'h210};
    tbl[3]  = '{"level_rst",   0, 16'h000, 32'h0,          4'h0, 1, 16'h018, 32'h0};
    tbl[4]  = '{"unmapped",    0, 16'h000, 32'h0,          4'h0, 1, 16'h008, 32'h0};
    tbl[5]  = '{"id_ro",       1, 16'h140, 32'hFFFFFFFF,   4'hF, 1, 16'h140, 32'hcafe0666};
    tbl[6]  = '{"unmapped_wr", 1, 16'h008, 32'hFFFFFFFF,   4'hF, 1, 16'h024, 32'h0};
    tbl[7]  = '{"",            1, 16'h010, 32'h7F,         4'h1, 0, 16'h000, 32'h0};
    tbl[8]  = '{"ctrl_33",     0, 16'h000, 32'h0,          4'h0, 1, 16'h010, 32'h33};
    tbl[9]  = '{"",            1, 16'h014, 32'h800000A5,   4'hF, 0, 16'h000, 32'h0};
    tbl[10] = '{"lpmode",      0, 16'h000, 32'h0,          4'h0, 1, 16'h014, 32'h800000A5};
    tbl[11] = '{"",            1, 16'h014, 32'h000000FF,   4'h8, 0, 16'h000, 32'h0};
    tbl[12] = '{"lpmode_strb", 0, 16'h000, 32'h0,          4'h0, 1, 16'h014, 32'h000000A5};
    tbl[13] = '{"",            1, 16'h024, 32'hF,          4'h0, 0, 16'h000, 32'h0};
    tbl[14] = '{"inten_strb",  0, 16'h000, 32'h0,          4'h0, 1, 16'h024, 32'h0};
    tbl[15] = '{"",            1, 16'h024, 32'hFFFFFFF2,   4'h1, 0, 16'h000, 32'h0};
    tbl[16] = '{"inten",       0, 16'h000, 32'h0,          4'h0, 1, 16'h024, 32'h2};
    tbl[17] = '{"",            1, 16'h010, 32'h0,          4'hE, 0, 16'h000, 32'h0};
    tbl[18] = '{"ctrl_strb",   0, 16'h000, 32'h0,          4'h0, 1, 16'h010, 32'h33};

    lb_wen = 0; lb_ren = 0; lb_waddr = BASE; lb_raddr = BASE; lb_wdata = 0; lb_wstrb = 0;
    tx_ready = 0; rx_data = 0; rx_ferr = 0; rx_perr = 0; rx_valid = 0; busy = 0;
    rst = 1; idle();
    rst = 1; idle();

    // Register table
    foreach (tbl[i]) begin
      lb_wen = tbl[i].wen; lb_waddr = BASE + tbl[i].wo; lb_wdata = tbl[i].wd; lb_wstrb = tbl[i].ws;
      lb_ren = tbl[i].ren; lb_raddr = BASE + tbl[i].ro;
      step(r);
      if (tbl[i].ren) chk(tbl[i].nm, r, tbl[i].exp);
    end

    // TX fill to full, overflow, drain order
    for (int i = 0; i < 16; i++) wr(16'h004, 32'h41 + i, 4'h1);
    rd_chk("level_txfull", 16'h018, 32'h10);
    rd_chk("stat_txf", 16'h00C, 32'h110);
    wr(16'h004, 32'h51, 4'h1);
    rd_chk("txovf", 16'h020, 32'h4);
    chk("tx_head", tx_data, 8'h41);
    tx_ready = 1;
    for (int i = 0; i < 16; i++) idle();
    tx_ready = 0;
    rd_chk("tx_int", 16'h020, 32'h5);
    wr(16'h020, 32'hF, 4'h1);

    // RX char with framing error, irq path
    rx_push(8'h5A, 1'b1, 1'b0);
    rx_ferr = 0;
    chk("irq_lag", irq, 1'b0);
    idle();
    chk("irq_rise", irq, 1'b1);
    rd_chk("rx_int", 16'h020, 32'h2);
    rd_chk("rx_data", 16'h004, 32'h1005A);
    rd_chk("stat_rxe", 16'h00C, 32'h210);
    wr(16'h020, 32'h2, 4'h1);
    idle();
    chk("irq_drop", irq, 1'b0);

    // TX start pulse
    wr(16'h010, 32'h7F, 4'h1);
    chk("txst_hi", ctrl_txst, 1'b1);
    idle();
    chk("txst_lo", ctrl_txst, 1'b0);

    // RX overflow racing a W1C of RXOVF: set wins
    for (int i = 0; i < 16; i++) rx_push(8'(i + 1), i[0], i[1]);
    rx_valid = 1; rx_data = 8'hEE;
    lb_wen = 1; lb_waddr = BASE + 16'h020; lb_wdata = 32'h8; lb_wstrb = 4'h1;
    step(r);
    rd_chk("rxovf_wins", 16'h020, 32'hA);
    wr(16'h020, 32'hF, 4'h1);

    // Full TX push coinciding with a pop
    for (int i = 0; i < 16; i++) wr(16'h004, 32'h60 + i, 4'h1);
    tx_ready = 1;
    wr(16'h004, 32'h99, 4'h1);
    tx_ready = 0;
    rd_chk("level_pushpop", 16'h018, 32'h00100010);
    rd_chk("no_txovf", 16'h020, 32'h0);

    // Reset with a read pending, FIFOs half full and irq asserted
    wr(16'h004, 32'h77, 4'h1);
    wr(16'h024, 32'hF, 4'h1);
    tx_ready = 1;
    for (int i = 0; i < 8; i++) idle();
    tx_ready = 0;
    for (int i = 0; i < 8; i++) begin
      lb_ren = 1; lb_raddr = BASE + 16'h004; step(r);
    end
    chk("irq_pre_rst", irq, 1'b1);
    rd_chk("level_half", 16'h018, 32'h00080008);
    rst = 1; lb_ren = 1; lb_raddr = BASE + 16'h018;
    step(r);
    chk("rst_rvalid", lb_rvalid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_txvalid", tx_valid, 1'b0);
    chk("rst_ctrl", {ctrl_baud, ctrl_txen, ctrl_rxen, ctrl_txst, lpmode_div, lpmode_en}, 32'h0);
    rd_chk("rst_level", 16'h018, 32'h0);
    rd_chk("rst_inten", 16'h024, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int k;
      busy = 1'($urandom);
      tx_ready = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 9) < 4) begin
        k = $urandom_range(0, 5);
        lb_wen = 1;
        lb_wdata = $urandom;
        lb_wstrb = 4'($urandom);
        case (k)
          0, 1, 2: lb_waddr = BASE + 16'h004;
          3: lb_waddr = BASE + 16'h020;
          4: lb_waddr = BASE + 16'h024;
          default: lb_waddr = BASE + 16'h010;
        endcase
      end
      if ($urandom_range(0, 9) < 5) begin
        k = $urandom_range(0, 6);
        lb_ren = 1;
        case (k)
          0, 1: lb_raddr = BASE + 16'h004;
          2: lb_raddr = BASE + 16'h00C;
          3: lb_raddr = BASE + 16'h018;
          4: lb_raddr = BASE + 16'h020;
          5: lb_raddr = BASE + 16'h024;
          default: lb_raddr = BASE + 16'h010;
        endcase
      end
      if ($urandom_range(0, 9) < 4) begin
        rx_valid = 1; rx_data = 8'($urandom); rx_ferr = 1'($urandom); rx_perr = 1'($urandom);
      end
      step(r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
